// File: rtl/led_frame_decoder_pkg.sv
// Shared types and default constants for the LED frame decoder.
package led_frame_decoder_pkg;

   localparam int DEF_NUM_LEDS     = 24;
   localparam int DEF_LOAD_CYCLES  = 4;
   localparam int DEF_LATCH_CYCLES = 2000;
   localparam int COLOR_W          = 24;

   // GRB word, MSB shifted out first
   typedef logic [COLOR_W-1:0] color_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RECV  = 3'd1,
      ST_LOAD  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_LATCH = 3'd4
   } state_t;

endpackage

// File: rtl/led_frame_decoder_spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous SPI line plus rise/fall detect.
module spi_sync_edge
   import led_frame_decoder_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic i_async,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   // Synchronizer chain; r_prev holds the last synchronized value for edge detect
   always_ff @(posedge clk) begin
      if (reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_level = r_sync;
   assign o_rise  = r_sync & ~r_prev;
   assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/led_frame_decoder.sv
// Receives GRB words over SPI into a frame buffer, then streams them to the
// LED control unit with a load/word_done handshake and a closing latch gap.
module led_frame_decoder
   import led_frame_decoder_pkg::*;
#(
   parameter int NUM_LEDS     = DEF_NUM_LEDS,
   parameter int LOAD_CYCLES  = DEF_LOAD_CYCLES,
   parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   sck,
   input  logic   sdi,
   input  logic   ce,
   input  logic   word_done,
   output color_t colorbits,
   output logic   load,
   output logic   busy,
   output logic   overflow,
   output logic   dropped
);

   localparam int PW = $clog2(NUM_LEDS + 1);
   localparam int LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
   localparam int TW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
   localparam logic [PW-1:0] FULL       = PW'(NUM_LEDS);
   localparam logic [LW-1:0] LOAD_LAST  = LW'(LOAD_CYCLES - 1);
   localparam logic [TW-1:0] LATCH_LAST = TW'(LATCH_CYCLES - 1);

   state_t          r_state;
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [PW-1:0]   r_count;
   logic [4:0]      r_bit_cnt;
   logic [22:0]     r_shift;
   logic [LW-1:0]   r_load_cnt;
   logic [TW-1:0]   r_latch_cnt;
   color_t          r_color;
   logic            r_overflow;
   logic            r_dropped;
   color_t          r_buf [NUM_LEDS];

   logic            w_sck_lvl, w_sck_rise, w_sck_fall;
   logic            w_sdi, w_sdi_rise, w_sdi_fall;
   logic            w_ce_lvl, w_ce_rise, w_ce_fall;
   logic            w_unused_edges;
   logic            w_bit_take;
   logic            w_wr_en;
   color_t          w_word;
   logic [PW-1:0]   w_rd_next;
   logic [PW-1:0]   w_rd_idx;
   color_t          w_rd_word;

   spi_sync_edge u_sck (.clk(clk), .reset(reset), .i_async(sck),
                        .o_level(w_sck_lvl), .o_rise(w_sck_rise), .o_fall(w_sck_fall));
   spi_sync_edge u_sdi (.clk(clk), .reset(reset), .i_async(sdi),
                        .o_level(w_sdi), .o_rise(w_sdi_rise), .o_fall(w_sdi_fall));
   spi_sync_edge u_ce  (.clk(clk), .reset(reset), .i_async(ce),
                        .o_level(w_ce_lvl), .o_rise(w_ce_rise), .o_fall(w_ce_fall));

   assign w_unused_edges = ^{w_sck_lvl, w_sck_fall, w_sdi_rise, w_sdi_fall};

   assign w_bit_take = (r_state == ST_RECV) && w_sck_rise && w_ce_lvl;
   assign w_word     = {r_shift, w_sdi};
   assign w_wr_en    = w_bit_take && (r_bit_cnt == 5'd23) && (r_wr_ptr != FULL);
   assign w_rd_next  = r_rd_ptr + PW'(1);
   // Single read port: slot 0 when a frame closes, next slot while streaming
   assign w_rd_idx   = (r_state == ST_RECV) ? '0 : w_rd_next;
   assign w_rd_word  = r_buf[w_rd_idx];

   // Frame buffer write port; contents deliberately survive reset and frames
   always_ff @(posedge clk) begin
      if (w_wr_en)
         r_buf[r_wr_ptr] <= w_word;
   end

   // Main receive/stream FSM with its pointers, counters and sticky flags
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_load_cnt  <= '0;
         r_latch_cnt <= '0;
         r_color     <= '0;
         r_overflow  <= 1'b0;
         r_dropped   <= 1'b0;
      end else begin
         // A new frame while streaming is refused; it never reaches RECV
         if (w_ce_rise && (r_state inside {ST_LOAD, ST_WAIT, ST_LATCH}))
            r_dropped <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (w_ce_rise) begin
                  r_state    <= ST_RECV;
                  r_wr_ptr   <= '0;
                  r_bit_cnt  <= '0;
                  r_overflow <= 1'b0;
                  r_dropped  <= 1'b0;
               end
            end
            ST_RECV: begin
               if (w_ce_fall) begin
                  r_bit_cnt <= '0;
                  if (r_wr_ptr == '0) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_state    <= ST_LOAD;
                     r_rd_ptr   <= '0;
                     r_count    <= r_wr_ptr;
                     r_load_cnt <= '0;
                     r_color    <= w_rd_word;
                  end
               end else if (w_bit_take) begin
                  r_shift <= w_word[22:0];
                  if (r_bit_cnt == 5'd23) begin
                     r_bit_cnt <= '0;
                     if (r_wr_ptr == FULL)
                        r_overflow <= 1'b1;
                     else
                        r_wr_ptr <= r_wr_ptr + PW'(1);
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 5'd1;
                  end
               end
            end
            ST_LOAD: begin
               if (r_load_cnt == LOAD_LAST)
                  r_state <= ST_WAIT;
               else
                  r_load_cnt <= r_load_cnt + LW'(1);
            end
            ST_WAIT: begin
               if (word_done) begin
                  r_rd_ptr <= w_rd_next;
                  if (w_rd_next < r_count) begin
                     r_state    <= ST_LOAD;
                     r_load_cnt <= '0;
                     r_color    <= w_rd_word;
                  end else begin
                     r_state     <= ST_LATCH;
                     r_latch_cnt <= '0;
                  end
               end
            end
            ST_LATCH: begin
               if (r_latch_cnt == LATCH_LAST)
                  r_state <= ST_IDLE;
               else
                  r_latch_cnt <= r_latch_cnt + TW'(1);
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign colorbits = r_color;
   assign load      = (r_state == ST_LOAD);
   assign busy      = !((r_state == ST_IDLE) || (r_state == ST_RECV));
   assign overflow  = r_overflow;
   assign dropped   = r_dropped;

endmodule

// File: tb/tb_led_frame_decoder.sv
// Frame-level bench: SPI host driver, LED-unit responder, load monitor and a
// queue model (streamed words = first NUM_LEDS complete words of the frame).
module tb_led_frame_decoder;
   import led_frame_decoder_pkg::*;

   localparam int NL = 24;
   localparam int LC = 4;
   localparam int LT = 2000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sck = 1'b0, sdi = 1'b0, ce = 1'b0, word_done = 1'b0;
   logic [23:0] colorbits;
   logic        load, busy, overflow, dropped;

   led_frame_decoder #(.NUM_LEDS(NL), .LOAD_CYCLES(LC), .LATCH_CYCLES(LT)) dut (
      .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .ce(ce),
      .word_done(word_done), .colorbits(colorbits), .load(load),
      .busy(busy), .overflow(overflow), .dropped(dropped));

   always #5 clk = ~clk;

   int nchk = 0;
   int nbad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- monitor: load pulses, their length, latch gap
   logic [23:0] obs_q[$];
   logic [23:0] run_col;
   int          run = 0, gap = 0, last_gap = 0, col_bad = 0;
   logic        pl_mon = 1'b0, pb_mon = 1'b0;

   initial forever begin
      @(negedge clk);
      if (load === 1'b1) begin
         if (!pl_mon) begin
            obs_q.push_back(colorbits);
            run_col = colorbits;
            run = 0;
         end else if (colorbits !== run_col) begin
            col_bad++;
         end
         run++;
      end else if (pl_mon && !reset) begin
         chk("load_len", run, LC);
      end
      if (busy === 1'b1 && load === 1'b0) gap++;
      else begin
         if (pb_mon && busy === 1'b0) last_gap = gap;
         gap = 0;
      end
      pl_mon = (load === 1'b1);
      pb_mon = (busy === 1'b1);
   end

   // ---------------- LED unit: word_done resp_dly cycles after load falls
   int   resp_dly = 1;
   logic pl_rsp = 1'b0;

   initial forever begin
      @(negedge clk);
      word_done = 1'b0;
      if (pl_rsp && load === 1'b0) begin
         repeat (resp_dly - 1) @(negedge clk);
         word_done = 1'b1;
      end
      pl_rsp = (load === 1'b1);
   end

   // ---------------- SPI host
   logic [23:0] tx_q[$];

   task automatic send_bits(input logic [23:0] w, input int n);
      for (int i = 0; i < n; i++) begin
         sdi = w[23-i];
         repeat (2) @(negedge clk);
         sck = 1'b1;
         repeat (2) @(negedge clk);
         sck = 1'b0;
      end
   endtask

   task automatic send_frame(input int nw, input int xb, input bit fixed);
      logic [23:0] w;
      tx_q.delete();
      for (int i = 0; i < nw; i++) begin
         if (fixed) w = (i == 0) ? 24'h123456 : 24'hABCDEF;
         else       w = 24'($urandom);
         tx_q.push_back(w);
      end
      @(negedge clk);
      ce = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < nw; i++) send_bits(tx_q[i], 24);
      if (xb > 0) send_bits(24'($urandom), xb);
      repeat (3) @(negedge clk);
      ce = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int k;
      k = 0;
      repeat (6) @(negedge clk);
      while (busy === 1'b1 && k < limit) begin
         @(negedge clk);
         k++;
      end
      chk("idle_reached_busy", busy, 0);
   endtask

   task automatic wait_load_fall(input int limit);
      int k;
      k = 0;
      while (load !== 1'b1 && k < limit) begin @(negedge clk); k++; end
      while (load === 1'b1 && k < limit) begin @(negedge clk); k++; end
      chk("load_fall_seen", (k < limit), 1);
   endtask

   // model: stream = first min(nw, NL) complete words, in order
   task automatic check_stream(input string tag, input int exp_n, input bit exp_ovf);
      chk({tag, "_pulses"}, obs_q.size(), exp_n);
      for (int i = 0; i < exp_n && i < obs_q.size(); i++)
         chk({tag, "_word"}, obs_q[i], tx_q[i]);
      chk({tag, "_overflow"}, overflow, exp_ovf);
   endtask

   typedef struct {
      int nw;
      int xb;
      int exp_n;
      bit exp_ovf;
      bit fixed;
   } vec_t;

   initial begin
      vec_t        vt[7];
      logic [23:0] keep_q[$];
      int          nw, xb, en;

      vt[0] = '{2,  0,  2,  1'b0, 1'b1};   // 0x123456, 0xABCDEF
      vt[1] = '{0,  0,  0,  1'b0, 1'b0};   // ce pulse with no sck
      vt[2] = '{1,  6,  1,  1'b0, 1'b0};   // 30 bits: partial tail discarded
      vt[3] = '{25, 0,  24, 1'b1, 1'b0};   // one word too many
      vt[4] = '{24, 0,  24, 1'b0, 1'b0};   // exactly full
      vt[5] = '{1,  23, 1,  1'b0, 1'b0};   // 47 bits
      vt[6] = '{0,  5,  0,  1'b0, 1'b0};   // only a partial word

      reset = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_load", load, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_dropped", dropped, 0);
      chk("rst_colorbits", colorbits, 0);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         resp_dly = 1;
         obs_q.delete();
         send_frame(vt[i].nw, vt[i].xb, vt[i].fixed);
         wait_idle(LT + vt[i].nw * 60 + 400);
         check_stream($sformatf("vec%0d", i), vt[i].exp_n, vt[i].exp_ovf);
         // busy-low-load span after the last word = WAIT cycles before word_done + latch gap
         if (vt[i].exp_n > 0) chk("latch_gap", last_gap, resp_dly + LT);
      end

      for (int r = 0; r < 5; r++) begin
         nw = $urandom_range(0, 26);
         xb = $urandom_range(0, 23);
         resp_dly = $urandom_range(1, 6);
         en = (nw > NL) ? NL : nw;
         obs_q.delete();
         send_frame(nw, xb, 1'b0);
         wait_idle(LT + nw * 60 + 400);
         check_stream($sformatf("rnd%0d", r), en, (nw > NL));
      end

      // new frame during WAIT: refused, stream unchanged
      resp_dly = 300;
      obs_q.delete();
      send_frame(2, 0, 1'b0);
      keep_q = tx_q;
      wait_load_fall(100);
      send_frame(1, 0, 1'b0);
      chk("drop_set", dropped, 1);
      tx_q = keep_q;
      wait_idle(LT + 1000);
      check_stream("drop", 2, 1'b0);
      chk("drop_sticky", dropped, 1);
      resp_dly = 2;
      obs_q.delete();
      send_frame(1, 0, 1'b0);
      wait_idle(LT + 400);
      check_stream("post_drop", 1, 1'b0);
      chk("drop_cleared", dropped, 0);

      // reset in the second WAIT aborts the frame
      resp_dly = 100;
      obs_q.delete();
      send_frame(3, 0, 1'b0);
      wait_load_fall(100);
      wait_load_fall(200);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_load", load, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_colorbits", colorbits, 0);
      reset = 1'b0;
      repeat (120) @(negedge clk);
      chk("midrst_pulses", obs_q.size(), 2);
      resp_dly = 3;
      obs_q.delete();
      send_frame(2, 0, 1'b0);
      wait_idle(LT + 400);
      check_stream("post_rst", 2, 1'b0);

      chk("load_colorbits_stable", col_bad, 0);
      $display("test done: total=%0d bad=%0d", nchk, nbad);
      $finish;
   end

endmodule

// File: doc/led_frame_decoder.md
LED_FRAME_DECODER -- requirements
Module: led_frame_decoder

Interface
REQ-001 The block SHALL have the parameter NUM_LEDS, default 24, giving the number of LEDs per strip and the frame buffer depth.
REQ-002 The block SHALL have the parameter LOAD_CYCLES, default 4, giving the number of clk cycles that load is held high per word.
REQ-003 The block SHALL have the parameter LATCH_CYCLES, default 2000, giving the number of idle-low clk cycles after a frame; this is the strip latch gap.
REQ-004 Port clk, input, 1: the single clock, same as fclk of the LED control unit; all logic is on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Ports sck, sdi, ce, input, 1 each: raw SPI from the host, asynchronous to clk; ce is active-high framing.
REQ-007 Port word_done, input, 1: a one-cycle pulse from the LED control unit when the current 24-bit word has been shifted out.
REQ-008 Port colorbits, output, 24: the GRB word presented to the LED control unit, MSB sent first.
REQ-009 Port load, output, 1: the load strobe to the LED control unit.
REQ-010 Port busy, output, 1: high in every state except IDLE and RECV.
REQ-011 Port overflow, output, 1: sticky; set when more than NUM_LEDS words arrive in one frame.
REQ-012 Port dropped, output, 1: sticky; set when ce rises while busy.

Function
REQ-013 sck, sdi and ce SHALL each pass through a 2-flop synchronizer; edges are detected on the synchronized copies, giving 3 clk cycles of input latency.
REQ-014 The FSM states SHALL be IDLE, RECV, LOAD, WAIT and LATCH.
REQ-015 IDLE -> RECV on a synchronized ce rise; at this transition wr_ptr, the bit count, overflow and dropped SHALL clear.
REQ-016 In RECV, each synchronized sck rise while ce is high SHALL shift sdi into a 24-bit shift register, MSB first.
REQ-017 In RECV, on the 24th bit the assembled word SHALL be written to buffer[wr_ptr], wr_ptr SHALL increment and the bit count SHALL reset.
REQ-018 When a 24th bit completes while wr_ptr == NUM_LEDS, the word SHALL be discarded, overflow SHALL set and wr_ptr SHALL hold.
REQ-019 In RECV, a synchronized ce fall SHALL discard any partial word (fewer than 24 bits).
REQ-020 On that ce fall, the FSM SHALL go to IDLE if wr_ptr == 0; otherwise it SHALL go to LOAD with rd_ptr = 0 and count = wr_ptr.
REQ-021 In LOAD, colorbits SHALL equal buffer[rd_ptr] and load SHALL be 1 for exactly LOAD_CYCLES cycles; the FSM then goes to WAIT.
REQ-022 In WAIT, load SHALL be 0 and colorbits SHALL hold stable.
REQ-023 On word_done in WAIT, rd_ptr SHALL increment; the FSM goes to LOAD if rd_ptr+1 < count, otherwise to LATCH.
REQ-024 word_done SHALL be ignored in every state except WAIT.
REQ-025 In LATCH, load SHALL be 0 for LATCH_CYCLES cycles, after which the FSM goes to IDLE.
REQ-026 A synchronized ce rise in LOAD, WAIT or LATCH SHALL set dropped; sck edges until the next IDLE SHALL be ignored.
REQ-027 A ce rise and a word_done in the same cycle SHALL both take effect.
REQ-028 The buffer SHALL retain its contents across frames; only indices below count are streamed.
REQ-029 wr_ptr, rd_ptr and count SHALL be $clog2(NUM_LEDS+1) bits wide; the latch and load counters SHALL be sized to their parameters.

Reset
REQ-030 When reset is high on a clk edge, the FSM SHALL enter IDLE and load, busy, overflow, dropped and colorbits SHALL be 0.
REQ-031 On the same edge, all pointers, the bit count and the synchronizer flops SHALL be 0.
REQ-032 Buffer contents are not reset and SHALL never be read before being written within the current frame.
REQ-033 Reset asserted mid-frame SHALL abort the frame with no further load pulses.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, the 24-bit color word typedef and the default constants.
REQ-035 One sub-module, spi_sync_edge, SHALL contain the 2-flop synchronizer plus the rise/fall detector; it is instantiated three times.
REQ-036 The frame buffer SHALL be an inferred single-write, single-read register array.

Verification
REQ-037 Two words 0x123456 and 0xABCDEF sent in one ce frame -> two LOAD phases of 4 cycles each with colorbits 0x123456 then 0xABCDEF, then 2000 low cycles, then IDLE.
REQ-038 25 words sent with NUM_LEDS=24 -> overflow=1, exactly 24 load pulses, and the 25th word never appears on colorbits.
REQ-039 30 bits sent (one word plus 6 bits) -> one load pulse with the first word; the partial 6 bits are discarded.
REQ-040 ce pulsed high with no sck -> no load pulse, FSM back in IDLE, busy=0.
REQ-041 A new ce frame started during WAIT -> dropped=1, the streamed words are unchanged, and the new frame's bits are ignored.
REQ-042 reset asserted during the second WAIT -> load=0 and busy=0 on the next cycle; a subsequent frame is received and streamed correctly.
